seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised Moore sequence detector, the next generation of the fixed-pattern `seq_det_moore`. It watches a serial bit stream qualified by an enable and asserts a registered detect flag when the last `PAT_W` accepted bits equal `PATTERN`. Pattern width, pattern value, overlap mode and a saturating hit counter are all configurable. It sits behind serial framing or shift-register sources, as `seq_det_moore` does.

## Interface
- `PAT_W`, 4, pattern length in bits (2..16).
- `PATTERN`, 4'b1011, pattern to match; MSB is the first bit received.
- `OVERLAP`, 1, 1 = matches may share bits; 0 = matching restarts after every detection.
- `CNT_W`, 8, hit counter width.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `i_enable`  in  1  qualifies `i_seq`; low = hold all state.
- `i_seq`  in  1  serial data bit, sampled on rising edge when `i_enable`=1.
- `i_clear`  in  1  synchronous clear of match state and counter.
- `o_detect`  out  1  Moore detect flag; high while the FSM is in the full-match state.
- `o_count`  out  CNT_W  number of detections since reset/clear, saturating.
- `o_match_len`  out  clog2(PAT_W+1)  current matched prefix length (debug).

## Operation
- States S0..S`PAT_W`; Sk = last accepted bits equal the first k bits of `PATTERN`. S`PAT_W` is the detect state.
- Transition on accepted bit b from Sk (k<`PAT_W`): to the longest prefix of `PATTERN` that is a suffix of (first k pattern bits, then b). This failure-function behaviour is required; a plain "mismatch -> S0" is wrong (e.g. 1011 followed by 0 must go to S2 under `OVERLAP`=1).
- From S`PAT_W`, `OVERLAP`=1: same rule with k=`PAT_W`. `OVERLAP`=0: the bit is processed as if from S0.
- `o_detect` = (state == S`PAT_W`); purely a state decode, registered, never a function of `i_seq`.
- `o_count` increments by 1 on every accepted bit whose next state is S`PAT_W`, including S`PAT_W`->S`PAT_W` (e.g. 1111 overlapping). Saturates at 2^`CNT_W`-1.
- `i_enable`=0: state, `o_detect` and `o_count` hold; a held S`PAT_W` keeps `o_detect` high but does not count again.
- Priority per edge: reset > `i_clear` > `i_enable`. `i_clear` -> S0, count 0; the bit on that edge is discarded.

## Timing
- Reset values: state S0, `o_detect`=0, `o_count`=0, `o_match_len`=0.
- Latency: `o_detect` rises on the same rising edge that samples the final pattern bit (visible the following cycle); it stays high exactly one enabled cycle unless the next accepted bit also completes a match.
- `o_count` updates on the same edge as `o_detect` rises.
- Reset or clear mid-pattern: partial match discarded; the next accepted bit is evaluated from S0.
- `i_rst_n` is sampled only at clock edges; asserting it between edges has no effect until the next edge.

## Structure
- Shared package `seq_det_pkg`: `clog2` function and `next_len(pattern, pat_w, k, b)` function computing the transition above; evaluated at elaboration into a constant next-state table (2*(`PAT_W`+1) entries).
- One sub-module: `sat_counter` (parameter `W`; inputs inc, clr; saturating output), reusable by other blocks.
- Top holds the state register, table lookup and detect decode.

## Test plan
- Defaults, enable held 1, stream 1,0,1,1,0,1,1 -> `o_detect` high after bit 4 and bit 7, `o_count`=2; `o_match_len` after bit 5 = 2.
- `OVERLAP`=0, same stream -> single detection after bit 4, `o_count`=1.
- `PATTERN`=4'b1111, `OVERLAP`=1, six 1s -> `o_detect` high for 3 consecutive cycles, `o_count`=3; with `OVERLAP`=0 -> `o_count`=1.
- Stream 1,0,1 with `i_enable` dropped 5 cycles, then 1 -> detection on the final bit; `o_count` unchanged while enable low, including holding in S4 afterwards.
- `CNT_W`=2, 5 matches -> `o_count` 1,2,3,3,3.
- `i_rst_n`=0 or `i_clear`=1 after bits 1,0,1, then 1 -> no detection; `o_match_len`=1; clear and enable in the same cycle -> clear wins.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
// Shared helpers for the parametrised sequence detector family.
//   clog2     : ceiling log2, used to size the match-length state.
//   next_len  : matched-prefix length after appending bit b to a k-bit
//               matched prefix (failure-function / KMP transition). Called
//               only at elaboration to build a constant next-state table.
// ----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // The pattern is read MSB-first: pattern[pat_w-1] is the first bit received.
  // Builds the sequence "first k pattern bits, then b" and returns the length
  // of the longest pattern prefix that is also a suffix of that sequence.
  function automatic int next_len(input logic [MAX_PAT_W-1:0] pattern,
                                  input int                   pat_w,
                                  input int                   k,
                                  input logic                 b);
    logic [MAX_PAT_W:0] s;
    int                 best;
    logic               hit;
    s    = '0;
    best = 0;
    for (int i = 0; i < k; i++) s[i] = pattern[pat_w-1-i];
    s[k] = b;
    for (int len = 1; (len <= pat_w) && (len <= k + 1); len++) begin
      hit = 1'b1;
      for (int j = 0; j < len; j++) begin
        if (s[k+1-len+j] != pattern[pat_w-1-j]) hit = 1'b0;
      end
      if (hit) best = len;
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   inc    in  add one (ignored once the counter is at all-ones)
//   clr    in  synchronous clear, wins over inc
//   count  out current value, W bits
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// ----------------------------------------------------------------------------
// seq_det_param
// Parametrised Moore sequence detector. The state is the length of the
// currently matched pattern prefix (S0..S<PAT_W>); S<PAT_W> is the detect
// state. Transitions come from a constant table built at elaboration.
//   i_clk        in  clock, rising edge
//   i_rst_n      in  synchronous active-low reset
//   i_enable     in  qualifies i_seq; low holds all state
//   i_seq        in  serial data bit
//   i_clear      in  synchronous clear of match state and hit counter
//   o_detect     out registered flag, high while in S<PAT_W>
//   o_count      out saturating number of detections since reset/clear
//   o_match_len  out current matched prefix length (debug)
// ----------------------------------------------------------------------------
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_seq,
  input  logic                        i_clear,
  output logic                        o_detect,
  output logic [CNT_W-1:0]            o_count,
  output logic [clog2(PAT_W+1)-1:0]   o_match_len
);

  localparam int LEN_W = clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

  logic [LEN_W-1:0] state;
  logic [LEN_W-1:0] next_state;
  logic             hit;

  // Indexed by {state, bit}. Without overlap the detect-state row reuses the
  // S0 transitions, so matching restarts after each detection.
  logic [LEN_W-1:0] next_tbl [2*(PAT_W+1)];

  for (genvar k = 0; k <= PAT_W; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int SRC = ((k == PAT_W) && !OVERLAP) ? 0 : k;
      assign next_tbl[2*k+b] =
        LEN_W'(next_len(MAX_PAT_W'(PATTERN), PAT_W, SRC, 1'(b)));
    end
  end

  assign next_state = next_tbl[{state, i_seq}];

  // Counts every accepted bit that lands in the detect state, including
  // staying there; a held detect state does not count again.
  assign hit = i_enable && !i_clear && (next_state == FULL);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= '0;
      o_detect <= 1'b0;
    end else if (i_clear) begin
      state    <= '0;
      o_detect <= 1'b0;
    end else if (i_enable) begin
      state    <= next_state;
      o_detect <= (next_state == FULL);
    end
  end

  assign o_match_len = state;

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (hit),
    .clr   (i_clear),
    .count (o_count)
  );

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, seq, clear;

  logic       det_a, det_b, det_c, det_d, det_e;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [1:0] cnt_e;
  logic [2:0] len_a, len_b, len_c, len_d, len_e;

  seq_det_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_seq(seq), .i_clear(clear),
    .o_detect(det_a), .o_count(cnt_a), .o_match_len(len_a));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_seq(seq), .i_clear(clear),
    .o_detect(det_b), .o_count(cnt_b), .o_match_len(len_b));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_seq(seq), .i_clear(clear),
    .o_detect(det_c), .o_count(cnt_c), .o_match_len(len_c));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_seq(seq), .i_clear(clear),
    .o_detect(det_d), .o_count(cnt_d), .o_match_len(len_d));
  seq_det_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_seq(seq), .i_clear(clear),
    .o_detect(det_e), .o_count(cnt_e), .o_match_len(len_e));

  // Reference model: keeps the raw accepted-bit history per configuration and
  // answers "how long a pattern prefix ends the history" by direct comparison.
  localparam int NCFG = 5;
  localparam int PW   = 4;
  int          pat  [NCFG] = '{'b1011, 'b1011, 'b1111, 'b1111, 'b1011};
  bit          ov   [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int          cmax [NCFG] = '{255, 255, 255, 255, 3};
  logic [31:0] hist [NCFG];
  int          hlen [NCFG];
  bit          restart [NCFG];
  int          mcnt [NCFG];

  int passes = 0;
  int total  = 0;

  function automatic int model_len(input int c);
    int best;
    bit ok;
    int p;
    best = 0;
    p    = pat[c];
    for (int l = 1; l <= PW && l <= hlen[c]; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (hist[c][l-1-j] != p[PW-1-j]) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input bit r, input bit e, input bit s, input bit cl);
    for (int c = 0; c < NCFG; c++) begin
      if (!r || cl) begin
        hist[c] = '0; hlen[c] = 0; restart[c] = 1'b0; mcnt[c] = 0;
      end else if (e) begin
        if (restart[c]) begin
          hist[c] = '0; hlen[c] = 0; restart[c] = 1'b0;
        end
        hist[c] = {hist[c][30:0], s};
        if (hlen[c] < 16) hlen[c]++;
        if (model_len(c) == PW) begin
          if (mcnt[c] < cmax[c]) mcnt[c]++;
          if (!ov[c]) restart[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] od [NCFG];
    logic [31:0] oc [NCFG];
    logic [31:0] ol [NCFG];
    int          l;
    od = '{32'(det_a), 32'(det_b), 32'(det_c), 32'(det_d), 32'(det_e)};
    oc = '{32'(cnt_a), 32'(cnt_b), 32'(cnt_c), 32'(cnt_d), 32'(cnt_e)};
    ol = '{32'(len_a), 32'(len_b), 32'(len_c), 32'(len_d), 32'(len_e)};
    for (int c = 0; c < NCFG; c++) begin
      l = model_len(c);
      check($sformatf("detect[%0d]", c), od[c], 32'(l == PW));
      check($sformatf("count[%0d]", c), oc[c], 32'(mcnt[c]));
      check($sformatf("match_len[%0d]", c), ol[c], 32'(l));
    end
  endtask

  // Drive away from the edge, let the edge happen, then compare 1 ns later.
  task automatic apply(input bit r, input bit e, input bit s, input bit cl);
    rst_n  = r;
    enable = e;
    seq    = s;
    clear  = cl;
    @(posedge clk);
    model_step(r, e, s, cl);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) apply(1'b1, 1'b1, v[i], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; seq = 1'b0; clear = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_detect", 32'(det_a), 32'd0);

    // Overlapping vs restarting detection on 1,0,1,1,0,1,1.
    feed(32'b10110, 5);
    check("len_after_bit5", 32'(len_a), 32'd2);
    feed(32'b11, 2);
    check("overlap_count", 32'(cnt_a), 32'd2);
    check("no_overlap_count", 32'(cnt_b), 32'd1);

    // Six ones against the all-ones pattern.
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    feed(32'b111111, 6);
    check("ones_overlap_count", 32'(cnt_c), 32'd3);
    check("ones_no_overlap_count", 32'(cnt_d), 32'd1);

    // Enable gap mid-pattern, then a held detect state.
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    feed(32'b101, 3);
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, i[0], 1'b0);
    feed(32'b1, 1);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b1, 1'b0);
    check("held_detect", 32'(det_a), 32'd1);
    check("held_count", 32'(cnt_a), 32'd1);

    // Saturation of the narrow counter.
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) feed(32'b1011, 4);
    check("sat_count", 32'(cnt_e), 32'd3);

    // Reset mid-pattern discards the partial match.
    feed(32'b101, 3);
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    feed(32'b1, 1);
    check("rst_mid_len", 32'(len_a), 32'd1);
    check("rst_mid_detect", 32'(det_a), 32'd0);

    // Clear together with enable: clear wins and the bit is dropped.
    feed(32'b101, 3);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    check("clear_wins_len", 32'(len_a), 32'd0);
    feed(32'b1, 1);
    check("clear_mid_len", 32'(len_a), 32'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
            1'($urandom), $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
